jtkunio_gfx_arb: RTL

Shares one 32-bit graphics ROM/SDRAM slot between the scroll tile fetcher (17-bit word address) and the object fetcher (18-bit word address). Each requester holds a one-entry tag/data buffer, so repeated reads of the same address are answered without a ROM access. Scroll has priority, and a streak counter stops the object layer from starving. The block sits between the scroll/object layers and the game's SDRAM bank-0 graphics port.

---
 rtl/jtkunio_gfx_arb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/jtkunio_gfx_arb.sv
// Arbitrates one 32-bit graphics ROM slot between the scroll and object fetchers.
// Each side keeps a one-word tag/data buffer so repeated reads of the same address skip the ROM.
module jtkunio_gfx_arb #(
   parameter int                SCR_AW   = 17,
   parameter int                OBJ_AW   = 18,
   parameter int                ROM_AW   = 19,
   parameter logic [ROM_AW-1:0] OBJ_BASE = 19'h20000,
   parameter int                MAXSCR   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              scr_cs,
   input  logic [SCR_AW-1:0] scr_addr,
   output logic [31:0]       scr_data,
   output logic              scr_ok,
   input  logic              obj_cs,
   input  logic [OBJ_AW-1:0] obj_addr,
   output logic [31:0]       obj_data,
   output logic              obj_ok,
   output logic              rom_cs,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   input  logic              rom_ok,
   output logic [1:0]        st_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      WAIT   = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [SCR_AW-1:0] scr_tag;
   logic [OBJ_AW-1:0] obj_tag;
   logic [OBJ_AW-1:0] lat_addr;
   logic              scr_valid, obj_valid;
   logic              gnt_obj;
   logic [2:0]        streak;
   logic              scr_hit, obj_hit, scr_pend, obj_pend;
   logic              grant_scr, grant_obj, fill;

   assign scr_hit  = scr_valid && (scr_tag == scr_addr);
   assign obj_hit  = obj_valid && (obj_tag == obj_addr);
   assign scr_ok   = scr_cs && scr_hit;
   assign obj_ok   = obj_cs && obj_hit;
   assign scr_pend = scr_cs && !scr_hit;
   assign obj_pend = obj_cs && !obj_hit;
   assign st_dbg   = state;

   always_comb begin
      state_nx  = state;
      grant_scr = 1'b0;
      grant_obj = 1'b0;
      fill      = 1'b0;
      case (state)
         IDLE: begin
            if (scr_pend && (!obj_pend || streak < 3'(MAXSCR))) begin
               grant_scr = 1'b1;
               state_nx  = SETTLE;
            end else if (obj_pend) begin
               grant_obj = 1'b1;
               state_nx  = SETTLE;
            end
         end
         // rom_ok from a previous access may still be high here, so it is ignored
         SETTLE: state_nx = WAIT;
         WAIT: begin
            if (rom_ok) begin
               fill     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_cs    <= 1'b0;
         rom_addr  <= '0;
         lat_addr  <= '0;
         gnt_obj   <= 1'b0;
         streak    <= 3'd0;
         scr_tag   <= '0;
         obj_tag   <= '0;
         scr_valid <= 1'b0;
         obj_valid <= 1'b0;
         scr_data  <= 32'd0;
         obj_data  <= 32'd0;
      end else begin
         if (grant_scr) begin
            rom_cs   <= 1'b1;
            rom_addr <= {{(ROM_AW-SCR_AW){1'b0}}, scr_addr};
            lat_addr <= {{(OBJ_AW-SCR_AW){1'b0}}, scr_addr};
            gnt_obj  <= 1'b0;
            if (!obj_pend)             streak <= 3'd0;
            else if (streak != 3'd7)   streak <= streak + 3'd1;
         end
         if (grant_obj) begin
            rom_cs   <= 1'b1;
            rom_addr <= OBJ_BASE + {{(ROM_AW-OBJ_AW){1'b0}}, obj_addr};
            lat_addr <= obj_addr;
            gnt_obj  <= 1'b1;
            streak   <= 3'd0;
         end
         if (fill) begin
            rom_cs <= 1'b0;
            if (!flush) begin
               if (gnt_obj) begin
                  obj_data  <= rom_data;
                  obj_tag   <= lat_addr;
                  obj_valid <= 1'b1;
               end else begin
                  scr_data  <= rom_data;
                  scr_tag   <= lat_addr[SCR_AW-1:0];
                  scr_valid <= 1'b1;
               end
            end
         end
         // flush outranks a fill landing in the same cycle
         if (flush) begin
            scr_valid <= 1'b0;
            obj_valid <= 1'b0;
         end
      end
   end

endmodule
